// File: rtl/quad_step_gen.sv
// Quadrature step generator: each accepted step plays one Gray-coded detent on {B,A}.
// It can add contact bounce on the changing bit and tracks the detent position.
module quad_step_gen #(
  parameter int PHASE_CYCLES  = 50000,
  parameter int BOUNCE_EDGES  = 0,
  parameter int BOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_valid,
  input  logic       step_dir,
  output logic       step_ready,
  output logic [1:0] ab_out,
  output logic       busy,
  output logic       step_done,
  output logic [7:0] pos
);

  localparam int CW    = $clog2(PHASE_CYCLES);
  localparam int BSEGS = 2 * BOUNCE_EDGES;
  localparam int SW    = (BSEGS > 1) ? $clog2(BSEGS + 1) : 1;
  localparam int BW    = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST     = CW'(PHASE_CYCLES - 1);
  localparam logic [SW-1:0] SEG_END  = SW'(BSEGS);
  localparam logic [BW-1:0] BCNT_END = BW'(BOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, PH3} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic [SW-1:0] r_bseg;
  logic [BW-1:0] r_bcnt;
  logic [1:0]    r_chg;
  logic          w_tc, w_accept, w_phase_start;
  logic [1:0]    w_code;

  // CCW order is 01,11,10,00; CW is the same walk with A and B swapped.
  function automatic logic [1:0] phase_code(input logic dir, input logic [1:0] ph);
    logic [1:0] g;
    case (ph)
      2'd0:    g = 2'b01;
      2'd1:    g = 2'b11;
      2'd2:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return dir ? {g[0], g[1]} : g;
  endfunction

  assign w_tc     = (r_cnt == LAST);
  assign w_accept = step_valid && (r_state == IDLE);

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_start = 1'b0;
    w_code        = 2'b00;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt = PH0; w_phase_start = 1'b1; w_code = phase_code(step_dir, 2'd0);
      end
      PH0: if (w_tc) begin
        w_state_nxt = PH1; w_phase_start = 1'b1; w_code = phase_code(r_dir, 2'd1);
      end
      PH1: if (w_tc) begin
        w_state_nxt = PH2; w_phase_start = 1'b1; w_code = phase_code(r_dir, 2'd2);
      end
      PH2: if (w_tc) begin
        w_state_nxt = PH3; w_phase_start = 1'b1; w_code = phase_code(r_dir, 2'd3);
      end
      PH3: if (w_tc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dir      <= 1'b0;
      r_bseg     <= '0;
      r_bcnt     <= '0;
      r_chg      <= 2'b00;
      ab_out     <= 2'b00;
      pos        <= 8'h00;
      step_ready <= 1'b1;
      busy       <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      step_ready <= (w_state_nxt == IDLE);
      busy       <= (w_state_nxt != IDLE);
      step_done  <= (r_state == PH3) && w_tc;
      if (w_accept) r_dir <= step_dir;
      if (r_state == IDLE || w_tc) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 1'b1;
      if (r_state == PH2 && w_tc) pos <= r_dir ? pos - 8'd1 : pos + 8'd1;
      // Bounce: toggle the changing bit at each segment end until 2N toggles land back on the new code.
      if (w_phase_start) begin
        ab_out <= w_code;
        r_chg  <= w_code ^ ab_out;
        r_bseg <= '0;
        r_bcnt <= '0;
      end else if (r_state != IDLE && r_bseg != SEG_END) begin
        if (r_bcnt == BCNT_END) begin
          r_bcnt <= '0;
          r_bseg <= r_bseg + 1'b1;
          ab_out <= ab_out ^ r_chg;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_step_gen.sv
// Bench for quad_step_gen: a clean and a bouncing instance share stimulus and
// are compared every cycle against a time-since-accept waveform model.
module tb_quad_step_gen;

  localparam int P  = 8;
  localparam int BC = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_valid = 1'b0;
  logic       step_dir = 1'b0;
  logic       rdy0, busy0, done0, rdy2, busy2, done2;
  logic [1:0] ab0, ab2;
  logic [7:0] pos0, pos2;

  quad_step_gen #(.PHASE_CYCLES(P), .BOUNCE_EDGES(0), .BOUNCE_CYCLES(BC)) u_clean (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_dir(step_dir),
    .step_ready(rdy0), .ab_out(ab0), .busy(busy0), .step_done(done0), .pos(pos0));

  quad_step_gen #(.PHASE_CYCLES(P), .BOUNCE_EDGES(2), .BOUNCE_CYCLES(BC)) u_bnc (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_dir(step_dir),
    .step_ready(rdy2), .ab_out(ab2), .busy(busy2), .step_done(done2), .pos(pos2));

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;
  int low_cnt, done_cnt;

  logic       m_busy, m_dir, m_done;
  int         m_t, m_acc = 0;
  logic [7:0] m_pos;
  logic [1:0] prev_ab0;
  logic [1:0] seq_ccw [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] seq_cw  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] code_of(input logic dir, input int ph);
    return dir ? seq_cw[ph] : seq_ccw[ph];
  endfunction

  // Expected ab for an instance with n bounce edges, from time since accept.
  function automatic logic [1:0] exp_ab(input int n);
    int ph, o;
    logic [1:0] nw, od;
    if (!m_busy) return 2'b00;
    ph = m_t / P;
    o  = m_t % P;
    nw = code_of(m_dir, ph);
    od = (ph == 0) ? 2'b00 : code_of(m_dir, ph - 1);
    if (o < 2 * n * BC && ((o / BC) % 2) == 1) return od;
    return nw;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_dir = 1'b0; m_done = 1'b0; m_t = 0; m_pos = 8'h00; prev_ab0 = 2'b00;
  endtask

  task automatic check_all();
    chk("ab_clean",  {6'd0, ab0},  {6'd0, exp_ab(0)});
    chk("ab_bounce", {6'd0, ab2},  {6'd0, exp_ab(2)});
    chk("ready",     {7'd0, rdy0}, {7'd0, !m_busy});
    chk("ready_b",   {7'd0, rdy2}, {7'd0, !m_busy});
    chk("busy",      {7'd0, busy0}, {7'd0, m_busy});
    chk("busy_b",    {7'd0, busy2}, {7'd0, m_busy});
    chk("done",      {7'd0, done0}, {7'd0, m_done});
    chk("done_b",    {7'd0, done2}, {7'd0, m_done});
    chk("pos",       pos0, m_pos);
    chk("pos_b",     pos2, m_pos);
    chk("gray", {7'd0, ($countones(ab0 ^ prev_ab0) <= 1)}, 8'd1);
    prev_ab0 = ab0;
  endtask

  // One cycle: check at negedge, drive inputs, then advance the model across the next posedge.
  task automatic cyc(input logic v, input logic d);
    @(negedge clk);
    check_all();
    if (!rdy0) low_cnt++;
    if (done0) done_cnt++;
    step_valid = v;
    step_dir   = d;
    m_done = 1'b0;
    if (!m_busy) begin
      if (v) begin m_busy = 1'b1; m_t = 0; m_dir = d; m_acc++; end
    end else begin
      m_t++;
      if (m_t == 3 * P) m_pos = m_dir ? m_pos - 8'd1 : m_pos + 8'd1;
      if (m_t == 4 * P) begin m_busy = 1'b0; m_done = 1'b1; end
    end
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    step_valid = 1'b0;
    #1;
    chk("rst_ab",    {6'd0, ab0}, 8'd0);
    chk("rst_ab_b",  {6'd0, ab2}, 8'd0);
    chk("rst_pos",   pos0, 8'd0);
    chk("rst_ready", {7'd0, rdy0}, 8'd1);
    chk("rst_busy",  {7'd0, busy0}, 8'd0);
    chk("rst_done",  {7'd0, done0}, 8'd0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int start, guard;
    model_reset();
    @(negedge clk);
    chk("init_ab",    {6'd0, ab0}, 8'd0);
    chk("init_ready", {7'd0, rdy0}, 8'd1);
    chk("init_pos",   pos0, 8'd0);
    #1 rst = 1'b0;

    // Single CCW detent
    low_cnt = 0; done_cnt = 0;
    cyc(1'b1, 1'b0);
    repeat (40) cyc(1'b0, 1'b0);
    chk("ccw_low_cycles", 8'(low_cnt), 8'd32);
    chk("ccw_done_count", 8'(done_cnt), 8'd1);
    chk("ccw_pos", pos0, 8'd1);

    // CW from zero wraps to FF
    do_rst();
    cyc(1'b1, 1'b1);
    repeat (40) cyc(1'b0, 1'b0);
    chk("cw_wrap_pos", pos0, 8'hFF);

    // Valid held high, alternating direction: exactly four detents
    do_rst();
    done_cnt = 0;
    start = m_acc;
    guard = 0;
    while (m_acc < start + 4 && guard < 400) begin
      cyc(1'b1, 1'((m_acc - start) % 2));
      guard++;
    end
    cyc(1'b0, 1'b0);
    repeat (40) cyc(1'b0, 1'b0);
    chk("b2b_done_count", 8'(done_cnt), 8'd4);
    chk("b2b_pos", pos0, 8'd0);

    // Reset in the middle of a step, then a normal step
    do_rst();
    done_cnt = 0;
    cyc(1'b1, 1'b0);
    repeat (11) cyc(1'b0, 1'b0);
    do_rst();
    repeat (3) cyc(1'b0, 1'b0);
    chk("midrst_no_done", 8'(done_cnt), 8'd0);
    cyc(1'b1, 1'b1);
    repeat (40) cyc(1'b0, 1'b0);
    chk("after_rst_pos", pos0, 8'hFF);
    chk("after_rst_done", 8'(done_cnt), 8'd1);

    // Random traffic
    repeat (1500) cyc(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    repeat (40) cyc(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
